// File: rtl/regcheck_pkg.sv
// Shared types for the register check engine: the controller state encoding and
// helpers that give the field offsets inside a packed trace entry {cycle, rd, rdata}.
package regcheck_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        ISSUE   = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_e;

    function automatic int trace_data_lsb();
        return 0;
    endfunction

    function automatic int trace_rd_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int trace_cyc_lsb(input int data_w, input int reg_aw);
        return data_w + reg_aw;
    endfunction

endpackage

// File: rtl/regcheck_trace_fifo.sv
// Synchronous FIFO that buffers processor regfile writes observed during RUN.
// A push on a full FIFO only succeeds if a pop happens in the same cycle.
module regcheck_trace_fifo #(
    parameter int WIDTH = 47,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_q];

    // NOTE: storage has no reset; the count and pointers alone decide what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/regfile_check_engine.sv
// Runs the processor for a cycle budget, then scans the regfile through read port A
// against an expected-value ROM. Optional write trace FIFO: define TRACE_FIFO_EN.
module regfile_check_engine
    import regcheck_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 32,
    parameter int REG_AW      = 5,
    parameter int CYC_W       = 10,
    parameter int ERR_W       = 6,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [CYC_W-1:0]              num_cycles,
    input  logic                          rwe,
    input  logic [REG_AW-1:0]             rd,
    input  logic [DATA_W-1:0]             rdata,
    output logic                          test_mode,
    output logic [REG_AW-1:0]             test_reg,
    input  logic [DATA_W-1:0]             reg_data,
    output logic [REG_AW-1:0]             exp_addr,
    input  logic [DATA_W-1:0]             exp_data,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [ERR_W-1:0]              error_count,
    output logic [CYC_W-1:0]              cycle_count,
    output logic                          fail_valid,
    output logic [REG_AW-1:0]             fail_reg,
    output logic [DATA_W-1:0]             fail_exp,
    output logic [DATA_W-1:0]             fail_act,
    output logic                          trace_valid,
    input  logic                          trace_ready,
    output logic [CYC_W+REG_AW+DATA_W-1:0] trace_data,
    output logic                          trace_ovf
);
    localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NUM_REGS - 1);

    state_e              state_q, state_d;
    logic [CYC_W-1:0]    budget_q, budget_d, cyc_q, cyc_d;
    logic [REG_AW-1:0]   idx_q, idx_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                fv_q, fv_d;
    logic [REG_AW-1:0]   freg_q, freg_d;
    logic [DATA_W-1:0]   fexp_q, fexp_d, fact_q, fact_d;
    logic                start_ok, run_last, mismatch;

    assign start_ok = start && (state_q == IDLE || state_q == DONE);
    assign run_last = (budget_q == '0) || (cyc_q == budget_q - CYC_W'(1));
    assign mismatch = (reg_data != exp_data);

    // NOTE: state flops use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (run_last) state_d = ISSUE;
            ISSUE:   state_d = COMPARE;
            COMPARE: state_d = (idx_q == LAST_IDX) ? DONE : ISSUE;
            DONE:    if (start_ok) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        test_mode = (state_q == ISSUE) || (state_q == COMPARE);
        busy      = (state_q == RUN) || test_mode;
        done      = (state_q == DONE);
    end

    always_comb begin
        budget_d = budget_q;
        cyc_d    = cyc_q;
        idx_d    = idx_q;
        err_d    = err_q;
        fv_d     = fv_q;
        freg_d   = freg_q;
        fexp_d   = fexp_q;
        fact_d   = fact_q;
        if (start_ok) begin
            budget_d = num_cycles;
            cyc_d    = '0;
            idx_d    = '0;
            err_d    = '0;
            fv_d     = 1'b0;
            freg_d   = '0;
            fexp_d   = '0;
            fact_d   = '0;
        end else if (state_q == RUN) begin
            if (cyc_q != budget_q) cyc_d = cyc_q + CYC_W'(1);
        end else if (state_q == COMPARE) begin
            if (mismatch) begin
                if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
                if (!fv_q) begin
                    fv_d   = 1'b1;
                    freg_d = idx_q;
                    fexp_d = exp_data;
                    fact_d = reg_data;
                end
            end
            if (idx_q != LAST_IDX) idx_d = idx_q + REG_AW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            budget_q <= '0;
            cyc_q    <= '0;
            idx_q    <= '0;
            err_q    <= '0;
            fv_q     <= 1'b0;
            freg_q   <= '0;
            fexp_q   <= '0;
            fact_q   <= '0;
        end else begin
            budget_q <= budget_d;
            cyc_q    <= cyc_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            fv_q     <= fv_d;
            freg_q   <= freg_d;
            fexp_q   <= fexp_d;
            fact_q   <= fact_d;
        end
    end

    assign test_reg    = idx_q;
    assign exp_addr    = idx_q;
    assign error_count = err_q;
    assign cycle_count = cyc_q;
    assign pass        = done && (err_q == '0);
    assign fail_valid  = fv_q;
    assign fail_reg    = freg_q;
    assign fail_exp    = fexp_q;
    assign fail_act    = fact_q;

`ifdef TRACE_FIFO_EN
    localparam int TW = CYC_W + REG_AW + DATA_W;

    logic [TW-1:0] entry;
    logic          push, pop, full, empty, ovf_q;

    always_comb begin
        entry = '0;
        entry[trace_data_lsb() +: DATA_W]               = rdata;
        entry[trace_rd_lsb(DATA_W) +: REG_AW]           = rd;
        entry[trace_cyc_lsb(DATA_W, REG_AW) +: CYC_W]   = cyc_q;
    end

    assign push = (state_q == RUN) && rwe && (rd != '0);
    assign pop  = trace_ready && !empty;

    regcheck_trace_fifo #(.WIDTH(TW), .DEPTH(TRACE_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (start_ok),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (entry),
        .rdata_o (trace_data),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clock) begin
        if (reset || start_ok)      ovf_q <= 1'b0;
        else if (push && full && !pop) ovf_q <= 1'b1;
    end

    assign trace_valid = !empty;
    assign trace_ovf   = ovf_q;
`else
    logic unused_trace;
    assign unused_trace = ^{trace_ready, rwe, rd, rdata, 1'(TRACE_DEPTH)};
    assign trace_valid  = 1'b0;
    assign trace_data   = '0;
    assign trace_ovf    = 1'b0;
`endif

endmodule
